// File: rtl/nios_system_com_nios_jtag_debug_host.sv
// Host-side virtual-JTAG scan engine for the Nios II debug module: one command in, one full IR/DR scan out.
// Latency: accept -> rsp_valid after 1 + (DR_WIDTH+4)*2*TCK_DIV clk (337 at defaults).
// Backpressure: cmd_ready only while idle, cmd_valid during a scan is ignored; rsp is a one-cycle pulse with no ready.
module nios_system_com_nios_jtag_debug_host #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    // A divider of 1 still needs a one-bit counter so the wrap compare stays legal.
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tck_q, tck_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DR_WIDTH-1:0] tx_q, tx_d;
    logic [DR_WIDTH-1:0] rx_q, rx_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;

    logic tck_run;
    logic div_wrap;
    logic rise_step;
    logic fall_step;

    // TCK only runs through the scan states; DONE and IDLE keep it parked low.
    assign tck_run   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign div_wrap  = (div_q == DIV_W'(TCK_DIV - 1));
    assign rise_step = tck_run && div_wrap && !tck_q;
    assign fall_step = tck_run && div_wrap && tck_q;

    // Next-state, divider, shift registers and response capture.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        tck_d       = tck_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        ir_in_d     = ir_in_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_ir_d    = rsp_ir_q;

        if (tck_run) begin
            div_d = div_wrap ? '0 : div_q + DIV_W'(1);
            if (div_wrap) begin
                tck_d = ~tck_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_UIR;
                    ir_in_d = cmd_ir;
                    tx_d    = cmd_data;
                    rx_d    = '0;
                    div_d   = '0;
                    tck_d   = 1'b0;
                    bit_d   = '0;
                end
            end
            S_UIR: begin
                if (fall_step) begin
                    state_d = S_CDR;
                end
            end
            S_CDR: begin
                if (rise_step) begin
                    rsp_ir_d = vji_ir_out;
                end
                if (fall_step) begin
                    state_d = S_SDR;
                    bit_d   = '0;
                end
            end
            S_SDR: begin
                // Target data is sampled on the rising step; ours advances on the falling step.
                if (rise_step) begin
                    rx_d = {vji_tdo, rx_q[DR_WIDTH-1:1]};
                end
                if (fall_step) begin
                    tx_d = tx_q >> 1;
                    if (bit_q == BIT_W'(DR_WIDTH - 1)) begin
                        state_d = S_UDR;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_UDR: begin
                if (fall_step) begin
                    state_d = S_RTI;
                end
            end
            S_RTI: begin
                // Registering the response here makes rsp_valid coincide with the DONE cycle.
                if (fall_step) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset mid-scan simply drops the scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            tck_q       <= 1'b0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            ir_in_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ir_q    <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            ir_in_q     <= ir_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ir_q    <= rsp_ir_d;
        end
    end

    // Strobes and TDI decode straight from registered state, so they only move on falling steps or accept.
    assign cmd_ready  = (state_q == S_IDLE);
    assign vji_uir    = (state_q == S_UIR);
    assign vji_cdr    = (state_q == S_CDR);
    assign vji_sdr    = (state_q == S_SDR);
    assign vji_udr    = (state_q == S_UDR);
    assign vji_rti    = (state_q == S_RTI);
    assign vji_tdi    = (state_q == S_SDR) && tx_q[0];
    assign vji_tck    = tck_q;
    assign vji_ir_in  = ir_in_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ir_out = rsp_ir_q;

endmodule
